// File: rtl/dmem_responder.sv
// Far end of the core's dmem interface: one request outstanding, word-array backed, fixed LATENCY response.
// Optional DMEM_JITTER_EN adds 0..3 LFSR-chosen wait cycles per request; drop_o flags requests seen while busy.
module dmem_responder #(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64,
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             dmem_rd_en_i,
  input  logic                             dmem_wr_en_i,
  input  logic [DATA_WIDTH-1:0]            dmem_addr_i,
  input  logic [$clog2(FETCH_WIDTH/8)-1:0] dmem_wr_size_i,
  input  logic [FETCH_WIDTH-1:0]           dmem_wr_data_i,
  output logic                             dmem_busy_o,
  output logic                             dmem_rdy_o,
  output logic [FETCH_WIDTH-1:0]           dmem_rd_data_o,
  output logic                             misalign_o,
  output logic                             drop_o
);
  localparam int BYTES = FETCH_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int CNTW  = 5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state;
  logic [CNTW-1:0]        cnt;
  logic [CNTW-1:0]        acc_cnt;
  logic                   req_wr;
  logic [IDXW-1:0]        req_idx;
  logic [OFFW-1:0]        req_off;
  logic [OFFW-1:0]        req_size;
  logic [FETCH_WIDTH-1:0] req_data;
  logic [FETCH_WIDTH-1:0] mem [DEPTH];

  logic                   req_any;
  logic                   accept;
  logic                   mem_we;
  int                     wr_nb;
  logic [FETCH_WIDTH-1:0] wr_word;
  logic [FETCH_WIDTH-1:0] wr_mask;
  logic                   wr_cross;
  logic [IDXW-1:0]        rd_idx;
  logic [FETCH_WIDTH-1:0] rd_word;

  wire unused_addr_hi = ^dmem_addr_i[DATA_WIDTH-1:OFFW+IDXW];

  assign req_any = dmem_rd_en_i | dmem_wr_en_i;
  assign accept  = (state != WAIT) && req_any;
  assign mem_we  = (state == RESP) && req_wr;
  assign drop_o  = dmem_busy_o & req_any;
  assign misalign_o = dmem_rdy_o & req_wr & wr_cross;

`ifdef DMEM_JITTER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign acc_cnt = CNTW'(LATENCY - 1) + CNTW'(lfsr[1:0]);
`else
  assign acc_cnt = CNTW'(LATENCY - 1);
`endif

  // Lane placement of the latched write; bytes that would spill past the word are dropped.
  always_comb begin
    wr_nb   = (int'(req_size) >= OFFW) ? BYTES : (1 << req_size);
    wr_word = '0;
    wr_mask = '0;
    for (int j = 0; j < BYTES; j++) begin
      if (j >= int'(req_off) && (j - int'(req_off)) < wr_nb) begin
        wr_mask[j*8 +: 8] = 8'hFF;
        wr_word[j*8 +: 8] = req_data[(j - int'(req_off))*8 +: 8];
      end
    end
    wr_cross = (int'(req_off) + wr_nb) > BYTES;
  end

  // A read accepted straight into RESP overlaps the previous write's commit edge, so forward it.
  always_comb begin
    rd_idx  = (state == WAIT) ? req_idx : dmem_addr_i[OFFW +: IDXW];
    rd_word = mem[rd_idx];
    if (mem_we && (req_idx == rd_idx))
      rd_word = (rd_word & ~wr_mask) | wr_word;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[req_idx] <= (mem[req_idx] & ~wr_mask) | wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      dmem_busy_o    <= 1'b0;
      dmem_rdy_o     <= 1'b0;
      dmem_rd_data_o <= '0;
      req_wr         <= 1'b0;
      req_idx        <= '0;
      req_off        <= '0;
      req_size       <= '0;
      req_data       <= '0;
    end else begin
      dmem_rdy_o <= 1'b0;
      case (state)
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            state       <= RESP;
            dmem_busy_o <= 1'b0;
            dmem_rdy_o  <= 1'b1;
            if (!req_wr) dmem_rd_data_o <= rd_word;
          end
        end
        default: begin
          // IDLE and RESP both accept, giving back-to-back turnaround out of RESP.
          if (accept) begin
            req_wr   <= dmem_wr_en_i;
            req_idx  <= dmem_addr_i[OFFW +: IDXW];
            req_off  <= dmem_addr_i[OFFW-1:0];
            req_size <= dmem_wr_size_i;
            req_data <= dmem_wr_data_i;
            cnt      <= acc_cnt;
            if (acc_cnt == '0) begin
              state      <= RESP;
              dmem_rdy_o <= 1'b1;
              if (!dmem_wr_en_i) dmem_rd_data_o <= rd_word;
            end else begin
              state       <= WAIT;
              dmem_busy_o <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level memory model with a response timeline, compared every cycle,
// plus directed literal checks for partial/misaligned writes, drops, reset mid-flight and aliasing.
module tb_dmem_responder;
  localparam int LAT   = 3;
  localparam int DEPTH = 64;
  localparam int BYTES = 8;
  localparam int SPAN  = DEPTH * BYTES;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] addr  = '0;
  logic [2:0]  size  = '0;
  logic [63:0] wdata = '0;
  logic        busy, rdy, misalign, drop;
  logic [63:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH(64), .FETCH_WIDTH(64), .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_rd_en_i(rd_en), .dmem_wr_en_i(wr_en), .dmem_addr_i(addr),
    .dmem_wr_size_i(size), .dmem_wr_data_i(wdata),
    .dmem_busy_o(busy), .dmem_rdy_o(rdy), .dmem_rd_data_o(rd_data),
    .misalign_o(misalign), .drop_o(drop)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: byte memory plus the single outstanding request and its response edge.
  logic [7:0]  mm [SPAN];
  int          cyc = 0;
  int          resp_edge = 0;
  bit          pend = 0;
  bit          p_wr = 0;
  logic [63:0] p_addr = '0;
  logic [2:0]  p_size = '0;
  logic [63:0] p_data = '0;
  bit          exp_rdy = 0, exp_busy = 0, exp_mis = 0;
  logic [63:0] exp_rd = '0;
  logic [7:0]  lfsr_m = 8'hA5;

  function automatic int nbytes(input logic [2:0] sz);
    int n;
    n = 1 << sz;
    return (n > BYTES) ? BYTES : n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0; exp_rdy = 0; exp_busy = 0; exp_mis = 0; exp_rd = '0; lfsr_m = 8'hA5;
    end else begin
      int extra, ab, off, n;
      cyc++;
      if (pend && resp_edge == cyc - 1) begin
        if (p_wr) begin
          ab = int'(p_addr % 64'(SPAN)); off = ab % BYTES; n = nbytes(p_size);
          for (int k = 0; k < n; k++)
            if (off + k < BYTES) mm[ab + k] = p_data[8*k +: 8];
        end
        pend = 0;
      end
      if (!pend && (rd_en || wr_en)) begin
        extra = 0;
`ifdef DMEM_JITTER_EN
        extra = int'(lfsr_m[1:0]);
`endif
        pend = 1; p_wr = wr_en; p_addr = addr; p_size = size; p_data = wdata;
        resp_edge = cyc + LAT - 1 + extra;
      end
`ifdef DMEM_JITTER_EN
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
      exp_rdy  = pend && resp_edge == cyc;
      exp_busy = pend && resp_edge > cyc;
      exp_mis  = 0;
      if (exp_rdy) begin
        ab = int'(p_addr % 64'(SPAN)); off = ab % BYTES; n = nbytes(p_size);
        exp_mis = p_wr && (off + n > BYTES);
        if (!p_wr)
          for (int b = 0; b < BYTES; b++) exp_rd[8*b +: 8] = mm[ab - off + b];
      end
    end
  end

  always @(negedge clk) begin
    check("rdy", 64'(rdy), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(exp_busy));
    check("misalign", 64'(misalign), 64'(exp_mis));
    check("drop", 64'(drop), 64'(exp_busy && (rd_en || wr_en)));
    check("rd_data", rd_data, exp_rd);
  end

  task automatic issue(input bit rd, input bit wr, input logic [63:0] a,
                       input logic [2:0] sz, input logic [63:0] d);
    #1;
    rd_en = rd; wr_en = wr; addr = a; size = sz; wdata = d;
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
  endtask

  task automatic wait_rdy(output logic [63:0] d, output bit m, output int bc, output int at);
    bit got = 0;
    d = '0; m = 0; bc = 0; at = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rdy) begin got = 1; d = rd_data; m = misalign; at = cyc; end
      else if (busy) bc++;
    end
    check("rdy_within_budget", 64'(got), 64'd1);
  endtask

  initial begin
    logic [63:0] d;
    bit m;
    int bc, t1, t2, n_rdy;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rdy", 64'(rdy), 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    @(posedge clk); #1 rst_n = 1;

    for (int w = 0; w < DEPTH; w++) begin
      issue(0, 1, 64'(w * BYTES), 3'd3, {$urandom, $urandom});
      wait_rdy(d, m, bc, t1);
    end

    issue(0, 1, 64'h18, 3'd3, 64'h0102030405060708); wait_rdy(d, m, bc, t1);
    issue(0, 1, 64'h10, 3'd3, 64'h1122334455667788); wait_rdy(d, m, bc, t1);
    check("t1_write_aligned", 64'(m), 64'd0);
    issue(1, 0, 64'h10, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t1_rd_data", d, 64'h1122334455667788);
`ifndef DMEM_JITTER_EN
    check("t1_busy_cycles", 64'(bc), 64'(LAT - 1));
`endif

    issue(0, 1, 64'h13, 3'd0, 64'hAB); wait_rdy(d, m, bc, t1);
    issue(1, 0, 64'h10, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t2_byte_write", d, 64'h11223344AB667788);

    issue(0, 1, 64'h16, 3'd2, 64'hDEADBEEF); wait_rdy(d, m, bc, t1);
    check("t3_misalign", 64'(m), 64'd1);
    issue(1, 0, 64'h10, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t3_lanes_6_7", d, 64'hBEEF3344AB667788);
    issue(1, 0, 64'h18, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t3_next_word", d, 64'h0102030405060708);

    issue(1, 0, 64'h10, 3'd0, 64'd0);
    rd_en = 1; addr = 64'h18;
    @(negedge clk);
    check("t4_drop", 64'(drop), 64'd1);
    @(posedge clk); #1 rd_en = 0;
    wait_rdy(d, m, bc, t1);
    check("t4_rd_data", d, 64'hBEEF3344AB667788);
    n_rdy = 0;
    repeat (LAT + 3) begin @(negedge clk); if (rdy) n_rdy++; end
    check("t4_no_extra_rdy", 64'(n_rdy), 64'd0);

    issue(1, 1, 64'h20, 3'd3, 64'hCAFEF00D12345678); wait_rdy(d, m, bc, t1);
    check("t4_write_keeps_rd_data", d, 64'hBEEF3344AB667788);
    issue(1, 0, 64'h20, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t4_rd_wr_is_write", d, 64'hCAFEF00D12345678);
    issue(1, 0, 64'h10, 3'd0, 64'd0); wait_rdy(d, m, bc, t2);
    check("t5_b2b_rd_data", d, 64'hBEEF3344AB667788);
`ifndef DMEM_JITTER_EN
    check("t5_b2b_spacing", 64'(t2 - t1), 64'(LAT));
`endif

    issue(0, 1, 64'h10, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    rst_n = 0;
    @(negedge clk);
    check("t5_reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst_n = 1;
    issue(1, 0, 64'h10, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t5_no_commit", d, 64'hBEEF3344AB667788);
    issue(1, 0, 64'(SPAN) + 64'h10, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t5_alias_read", d, 64'hBEEF3344AB667788);
    issue(0, 1, 64'(SPAN) + 64'h28, 3'd3, 64'h5A5A0F0F33339999); wait_rdy(d, m, bc, t1);
    issue(1, 0, 64'h28, 3'd0, 64'd0); wait_rdy(d, m, bc, t1);
    check("t5_alias_write", d, 64'h5A5A0F0F33339999);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 99) < 45) begin
        wr_en = 1'($urandom_range(0, 1));
        rd_en = !wr_en || ($urandom_range(0, 3) == 0);
        addr  = 64'($urandom_range(0, 2 * SPAN - 1));
        size  = 3'($urandom_range(0, 7));
        wdata = {$urandom, $urandom};
      end else begin
        rd_en = 0; wr_en = 0;
      end
    end
    @(posedge clk); #1 rd_en = 0; wr_en = 0;
    repeat (LAT + 8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
